// File: rtl/jtkcpu_useq.sv
// Microcode address sequencer with a small call/return stack and prioritised interrupt channels.
// Sits between the opcode decoder and the ucode ROM; all state advances only while cen is high.
module jtkcpu_useq #(
   parameter int AW = 10,
   parameter int CATW = 6,
   parameter int NINT = 3,
   parameter logic [NINT-1:0] EDGE = 3'b100,
   parameter int SD = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cen,
   input  logic                 stall,
   input  logic                 ni,
   input  logic [CATW-1:0]      opcat,
   input  logic                 uc_loop,
   input  logic                 jmp,
   input  logic [CATW-1:0]      jmp_cat,
   input  logic                 call,
   input  logic                 ret,
   input  logic [NINT-1:0]      int_n,
   input  logic [NINT-1:0]      int_mask,
   input  logic [NINT*CATW-1:0] int_cat,
   input  logic [CATW-1:0]      rst_cat,
   output logic [AW-1:0]        addr,
   output logic [NINT-1:0]      cur_int,
   output logic                 intsrv,
   output logic                 stk_err
);
   localparam int SPW = $clog2(SD + 1);
   localparam int SDEPTH = 1 << SPW;
   localparam logic [SPW-1:0] SD_FULL = SPW'(SD);

   logic [AW-1:0]   addr_reg, addr_next, addr_inc;
   logic [NINT-1:0] cur_reg, cur_next;
   logic [NINT-1:0] int_l_reg, pend_reg, pend_next;
   logic [SPW-1:0]  sp_reg, sp_next, sp_dec;
   logic            err_reg, err_next;
   logic            nil_reg, nil_next;
   logic [AW-1:0]   stk [0:SDEPTH-1];
   logic            push, take_int, any_elig;
   logic [NINT-1:0] req, elig, pend_set, win_oh;
   logic [CATW-1:0] win_cat;

   function automatic logic [AW-1:0] entry(input logic [CATW-1:0] cat);
      return {cat, {(AW-CATW){1'b0}}};
   endfunction

   // Edge channels request from their latch; level channels straight from the pin.
   genvar gi;
   generate
      for (gi = 0; gi < NINT; gi++) begin : g_ch
         assign req[gi]      = EDGE[gi] ? pend_reg[gi] : ~int_n[gi];
         assign pend_set[gi] = EDGE[gi] & int_l_reg[gi] & ~int_n[gi];
      end
   endgenerate

   assign elig   = req & ~int_mask;
   assign intsrv = |elig;

   // Lowest-numbered eligible channel wins: scan downwards so it is assigned last.
   always_comb begin
      any_elig = 1'b0;
      win_oh   = '0;
      win_cat  = '0;
      for (int k = NINT - 1; k >= 0; k--) begin
         if (elig[k]) begin
            any_elig   = 1'b1;
            win_oh     = '0;
            win_oh[k]  = 1'b1;
            win_cat    = int_cat[k*CATW +: CATW];
         end
      end
   end

   assign addr_inc = addr_reg + AW'(1);
   assign sp_dec   = sp_reg - SPW'(1);

   always_comb begin
      addr_next = addr_reg;
      cur_next  = cur_reg;
      sp_next   = sp_reg;
      err_next  = err_reg;
      push      = 1'b0;
      take_int  = 1'b0;
      if (ret) begin
         if (sp_reg == '0) begin
            addr_next = entry(rst_cat);
            err_next  = 1'b1;
         end else begin
            addr_next = stk[sp_dec];
            sp_next   = sp_dec;
         end
      end else if (call) begin
         addr_next = entry(jmp_cat);
         if (sp_reg == SD_FULL) begin
            err_next = 1'b1;
         end else begin
            push    = 1'b1;
            sp_next = sp_reg + SPW'(1);
         end
      end else if (jmp) begin
         addr_next = entry(jmp_cat);
      end else if (uc_loop) begin
         addr_next = entry(opcat);
      end else if (nil_reg) begin
         addr_next = entry(opcat);
         cur_next  = '0;
      end else if (ni && any_elig) begin
         addr_next = entry(win_cat);
         cur_next  = win_oh;
         take_int  = 1'b1;
      end else if (!stall) begin
         addr_next = addr_inc;
      end
      // A fresh edge arriving while the same channel is serviced is kept.
      pend_next = (pend_reg & ~({NINT{take_int}} & win_oh & EDGE)) | pend_set;
      nil_next  = ni & ~take_int;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg  <= entry(rst_cat);
         cur_reg   <= '0;
         int_l_reg <= '1;
         pend_reg  <= '0;
         sp_reg    <= '0;
         err_reg   <= 1'b0;
         nil_reg   <= 1'b0;
      end else if (cen) begin
         addr_reg  <= addr_next;
         cur_reg   <= cur_next;
         int_l_reg <= int_n;
         pend_reg  <= pend_next;
         sp_reg    <= sp_next;
         err_reg   <= err_next;
         nil_reg   <= nil_next;
      end
   end

   always_ff @(posedge clk) begin
      if (cen && push) begin
         stk[sp_reg] <= addr_inc;
      end
   end

   assign addr    = addr_reg;
   assign cur_int = cur_reg;
   assign stk_err = err_reg;
endmodule
